mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency memory between the pipelined machine's instruction-fetch port and its data (load/store) port.
- Arbitrates between the two ports and sequences each access over LATENCY cycles.
- Returns read data to the winning port and drives per-port stall signals that freeze the pipeline registers while an access is outstanding.
- Data port has priority. A streak limit prevents fetch starvation.

---
 rtl/arbiter_pkg.sv | 21 ++
 rtl/arb_priority_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEFAULT_LATENCY    = 2;
  localparam int DEFAULT_STREAK_MAX = 3;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner selection: data first, unless a waiting fetch has
// already been passed over STREAK_MAX times in a row.
module arb_priority_pick
  import arbiter_pkg::*;
#(
  parameter int STREAK_MAX = DEFAULT_STREAK_MAX,
  parameter int STREAK_W   = width_of(STREAK_MAX + 1)
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                any_req,
  output logic                grant
);

  logic fetch_due;

  always_comb begin
    fetch_due = if_req && (streak == STREAK_W'(STREAK_MAX));
    any_req   = if_req || d_req;
    grant     = (d_req && !fetch_due) ? GRANT_D : GRANT_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch and data
// ports; each access runs IDLE -> ACCESS (LATENCY cycles) -> DONE.
module mem_port_arbiter
  import arbiter_pkg::*;
#(
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int STREAK_MAX = DEFAULT_STREAK_MAX,
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              stall_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall_d,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W    = width_of(LATENCY + 1);
  localparam int STREAK_W = width_of(STREAK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [STREAK_W-1:0] streak;
  logic                grant_d;
  logic                we_lat;
  logic                any_req;
  logic                pick;

  arb_priority_pick #(
    .STREAK_MAX (STREAK_MAX),
    .STREAK_W   (STREAK_W)
  ) u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .streak  (streak),
    .any_req (any_req),
    .grant   (pick)
  );

  assign stall_if = if_req && !if_ready;
  assign stall_d  = d_req && !d_ready;

  // Strobes are registered one state ahead so they line up exactly with the
  // ACCESS cycles; the store strobe is armed only for the last of them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      grant_d   <= 1'b0;
      we_lat    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d <= (pick == GRANT_D);
            cnt     <= '0;
            state   <= ACCESS;
            if (pick == GRANT_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              we_lat    <= d_we;
              mem_re    <= !d_we;
              mem_we    <= d_we && (LATENCY == 1);
              streak    <= if_req ? streak + STREAK_W'(1) : '0;
            end else begin
              mem_addr <= if_addr;
              we_lat   <= 1'b0;
              mem_re   <= 1'b1;
              mem_we   <= 1'b0;
              streak   <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            state    <= DONE;
            if_ready <= !grant_d;
            d_ready  <= grant_d;
            if (!we_lat) begin
              if (grant_d) d_rdata <= mem_rdata;
              else         if_rdata <= mem_rdata;
            end
          end else begin
            cnt    <= cnt + CNT_W'(1);
            mem_we <= we_lat && (cnt == CNT_LAST - CNT_W'(1));
          end
        end
        DONE: begin
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// grants, strobes and returned data; a monitor compares every cycle.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 3;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    int          gcyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [29:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        stall_if;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        stall_d;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gap_max = 0;

  logic [29:0] if_todo[$];
  dreq_t       d_todo[$];
  exp_t        exp_q[$];
  int          dut_order[$];

  logic [31:0] dev_mem[logic [29:0]];
  logic [31:0] shadow[logic [29:0]];

  logic        if_seen = 1'b0;
  logic        d_seen = 1'b0;
  int          if_issue_cyc = 0;
  int          d_issue_cyc = 0;
  int          last_if_rdy = 0;
  int          last_d_rdy = 0;
  int          free_at = 0;
  int          m_streak = 0;
  logic [31:0] held_if = '0;
  logic [31:0] held_d = '0;

  mem_port_arbiter #(
    .LATENCY    (LAT),
    .STREAK_MAX (SMAX),
    .ADDR_W     (30),
    .DATA_W     (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .stall_if  (stall_if),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .stall_d   (stall_d),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] rom(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory device: reads are presented a half cycle ahead of the capturing edge.
  always @(negedge clk) begin
    if (mem_we) dev_mem[mem_addr] = mem_wdata;
    mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : rom(mem_addr);
  end

  always @(negedge clk) begin
    if_seen = if_ready;
    d_seen  = d_ready;
  end

  initial begin : fetch_agent
    int wait_n;
    wait_n  = 0;
    if_req  = 1'b0;
    if_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (if_req && if_seen) begin
        if_req = 1'b0;
        wait_n = $urandom_range(0, gap_max);
      end
      if (!if_req && if_todo.size() > 0) begin
        if (wait_n > 0) wait_n--;
        else begin
          if_req       = 1'b1;
          if_addr      = if_todo.pop_front();
          if_issue_cyc = cyc;
        end
      end
    end
  end

  initial begin : data_agent
    int    wait_n;
    dreq_t t;
    wait_n  = 0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (d_req && d_seen) begin
        d_req  = 1'b0;
        wait_n = $urandom_range(0, gap_max);
      end
      if (!d_req && d_todo.size() > 0) begin
        if (wait_n > 0) wait_n--;
        else begin
          t           = d_todo.pop_front();
          d_req       = 1'b1;
          d_we        = t.we;
          d_addr      = t.addr;
          d_wdata     = t.wdata;
          d_issue_cyc = cyc;
        end
      end
    end
  end

  // Reference model: whenever the memory is free and someone asks, decide the
  // winner from the priority/starvation rule and predict the whole transaction.
  always @(negedge clk) begin : model_p
    exp_t e;
    logic win_d;
    if (reset) begin
      exp_q.delete();
      free_at  = 0;
      m_streak = 0;
    end else if (cyc >= free_at && (if_req || d_req)) begin
      win_d    = d_req && !(if_req && m_streak == SMAX);
      m_streak = (win_d && if_req) ? m_streak + 1 : 0;
      e.is_d   = win_d;
      e.gcyc   = cyc;
      e.wdata  = '0;
      e.data   = '0;
      if (win_d) begin
        e.we    = d_we;
        e.addr  = d_addr;
        e.wdata = d_wdata;
        if (d_we) shadow[d_addr] = d_wdata;
        else e.data = shadow.exists(d_addr) ? shadow[d_addr] : rom(d_addr);
      end else begin
        e.we   = 1'b0;
        e.addr = if_addr;
        e.data = shadow.exists(if_addr) ? shadow[if_addr] : rom(if_addr);
      end
      exp_q.push_back(e);
      free_at = cyc + LAT + 2;
    end
  end

  always @(negedge clk) begin : monitor_p
    exp_t t;
    logic exp_re, exp_we, exp_ir, exp_dr;
    if (reset) begin
      held_if = '0;
      held_d  = '0;
      check_output("rst_mem_re", mem_re, 0);
      check_output("rst_mem_we", mem_we, 0);
      check_output("rst_if_ready", if_ready, 0);
      check_output("rst_d_ready", d_ready, 0);
      check_output("rst_if_rdata", if_rdata, 0);
      check_output("rst_d_rdata", d_rdata, 0);
      check_output("rst_mem_addr", mem_addr, 0);
      check_output("rst_mem_wdata", mem_wdata, 0);
      check_output("rst_stall_if", stall_if, if_req);
    end else begin
      exp_re = 1'b0;
      exp_we = 1'b0;
      exp_ir = 1'b0;
      exp_dr = 1'b0;
      if (exp_q.size() > 0) begin
        t = exp_q[0];
        if (cyc > t.gcyc && cyc <= t.gcyc + LAT) begin
          exp_re = !t.we;
          exp_we = t.we && (cyc == t.gcyc + LAT);
          check_output("mem_addr", mem_addr, t.addr);
          if (exp_we) check_output("mem_wdata", mem_wdata, t.wdata);
        end else if (cyc == t.gcyc + LAT + 1) begin
          if (t.is_d) begin
            exp_dr = 1'b1;
            if (!t.we) held_d = t.data;
          end else begin
            exp_ir  = 1'b1;
            held_if = t.data;
          end
          void'(exp_q.pop_front());
        end
      end
      check_output("mem_re", mem_re, exp_re);
      check_output("mem_we", mem_we, exp_we);
      check_output("if_ready", if_ready, exp_ir);
      check_output("d_ready", d_ready, exp_dr);
      check_output("stall_if", stall_if, if_req && !exp_ir);
      check_output("stall_d", stall_d, d_req && !exp_dr);
      check_output("if_rdata", if_rdata, held_if);
      check_output("d_rdata", d_rdata, held_d);
      if (if_ready) begin
        last_if_rdy = cyc;
        dut_order.push_back(0);
      end
      if (d_ready) begin
        last_d_rdy = cyc;
        dut_order.push_back(1);
      end
    end
  end

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (if_todo.size() == 0) && (d_todo.size() == 0) && !if_req && !d_req &&
             (exp_q.size() == 0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL wait_idle: traffic still pending after %0d cycles, expected drained", budget);
    end
  endtask

  task automatic apply_stimulus(input logic is_d, input logic we, input logic [29:0] addr,
                                input logic [31:0] wdata);
    dreq_t t;
    if (is_d) begin
      t.we    = we;
      t.addr  = addr;
      t.wdata = wdata;
      d_todo.push_back(t);
    end else begin
      if_todo.push_back(addr);
    end
  endtask

  initial begin : main
    logic [31:0] before_store;
    int          rel;
    int          exp_order[6];
    dev_mem[30'h100000] = 32'h2002000A;
    shadow[30'h100000]  = 32'h2002000A;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("idle_mem_re", mem_re, 0);

    apply_stimulus(1'b0, 1'b0, 30'h100000, '0);
    wait_idle(60);
    check_output("fetch_latency", last_if_rdy - if_issue_cyc, LAT + 1);
    check_output("fetch_data", if_rdata, 32'h2002000A);

    dut_order.delete();
    apply_stimulus(1'b1, 1'b0, 30'h04000004, '0);
    apply_stimulus(1'b0, 1'b0, 30'h100004, '0);
    wait_idle(60);
    check_output("simul_d_ready_cycle", last_d_rdy - d_issue_cyc, 3);
    check_output("simul_if_ready_cycle", last_if_rdy - if_issue_cyc, 7);
    check_output("simul_order_len", dut_order.size(), 2);
    if (dut_order.size() == 2) begin
      check_output("simul_first_d", dut_order[0], 1);
      check_output("simul_second_if", dut_order[1], 0);
    end

    before_store = held_d;
    apply_stimulus(1'b1, 1'b1, 30'h04000008, 32'hDEADBEEF);
    wait_idle(60);
    check_output("store_ready_cycle", last_d_rdy - d_issue_cyc, 3);
    check_output("store_keeps_d_rdata", d_rdata, before_store);
    apply_stimulus(1'b1, 1'b0, 30'h04000008, '0);
    wait_idle(60);
    check_output("load_after_store", d_rdata, 32'hDEADBEEF);

    dut_order.delete();
    exp_order = '{1, 1, 1, 0, 1, 1};
    apply_stimulus(1'b0, 1'b0, 30'h100008, '0);
    for (int k = 0; k < 5; k++) apply_stimulus(1'b1, 1'b0, 30'h04000010 + 30'(k), '0);
    wait_idle(200);
    check_output("streak_order_len", dut_order.size(), 6);
    for (int k = 0; k < 6 && k < dut_order.size(); k++)
      check_output($sformatf("streak_order_%0d", k), dut_order[k], exp_order[k]);

    dut_order.delete();
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 30'h10000C, '0);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    check_output("mid_access_mem_re", mem_re, 1);
    reset = 1'b1;
    #1;
    check_output("async_mem_re_drop", mem_re, 0);
    check_output("async_if_ready", if_ready, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    rel   = cyc;
    wait_idle(60);
    check_output("reset_refetch_cycle", last_if_rdy - rel, LAT + 1);
    check_output("reset_single_ready", dut_order.size(), 1);

    gap_max = 3;
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(1'b0, 1'b0, 30'h100000 + 30'($urandom_range(0, 15)), '0);
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 30'h04000000 + 30'($urandom_range(0, 15)),
                     $urandom);
    end
    wait_idle(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
